// File: rtl/native_mem_responder_if.sv
// picorv32 native memory bus (mem_valid/mem_ready handshake) between a core and a memory slave.
interface native_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/native_mem_responder.sv
// Word memory slave for the picorv32 native bus: fixed wait states, range check, access counters.
// Optional MEM_RAND_STALL_EN adds 0..3 pseudo-random extra wait cycles per request from an LFSR.
module native_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 0,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                        clk,
  input  logic                        reset,
  native_mem_responder_if.slave       bus,
  output logic                        range_err,
  output logic                        proto_err,
  output logic [31:0]                 cnt_ifetch,
  output logic [31:0]                 cnt_dread,
  output logic [31:0]                 cnt_dwrite
);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) * 32'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state, state_nxt;
  logic [4:0]  wait_cnt, wait_nxt;
  logic [4:0]  extra;
  req_t        req;
  logic        accept, commit, abort;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] offset;
  logic        in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

`ifdef MEM_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset)       lfsr <= 16'hACE1;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = 5'd0;
`endif

  // Everything after acceptance works from the latched request, never the live bus.
  assign offset   = req.addr - BASE_ADDR;
  assign in_range = (req.addr >= BASE_ADDR) && (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (bus.mem_valid) begin
        accept    = 1'b1;
        state_nxt = WAIT;
        wait_nxt  = 5'(LATENCY) + extra;
      end
      WAIT: begin
        if (!bus.mem_valid) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == 5'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          wait_nxt  = wait_cnt - 5'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 5'd0;
      req        <= '0;
      ready      <= 1'b0;
      rdata      <= 32'd0;
      range_err  <= 1'b0;
      proto_err  <= 1'b0;
      cnt_ifetch <= 32'd0;
      cnt_dread  <= 32'd0;
      cnt_dwrite <= 32'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      ready     <= commit;
      range_err <= commit && !in_range;
      if (accept)
        req <= '{instr: bus.mem_instr, addr: bus.mem_addr,
                 wdata: bus.mem_wdata, wstrb: bus.mem_wstrb};
      if (commit) begin
        if (req.wstrb != 4'd0) rdata <= 32'd0;
        else if (in_range)     rdata <= mem[idx];
        else                   rdata <= ERR_RDATA;
      end
      if (abort) proto_err <= 1'b1;
      if (state == RESP) begin
        if (req.instr)               cnt_ifetch <= sat_inc(cnt_ifetch);
        else if (req.wstrb != 4'd0)  cnt_dwrite <= sat_inc(cnt_dwrite);
        else                         cnt_dread  <= sat_inc(cnt_dread);
      end
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && !reset && in_range) begin
      for (int b = 0; b < 4; b++)
        if (req.wstrb[b]) mem[idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end

  assign bus.mem_ready = ready;
  assign bus.mem_rdata = rdata;
endmodule

// File: tb/tb_native_mem_responder.sv
// Directed bench: one responder at LATENCY=0 and one at LATENCY=3, sharing clock and reset.
module tb_native_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  native_mem_responder_if b0();
  native_mem_responder_if b3();

  logic        dv [2];
  logic        di [2];
  logic [31:0] da [2];
  logic [31:0] dwd[2];
  logic [3:0]  dws[2];
  logic        rdy [2];
  logic [31:0] rdat[2];
  logic        rerr[2];
  logic        perr[2];
  logic [31:0] cif[2], cdr[2], cdw[2];

  assign b0.mem_valid = dv[0];  assign b3.mem_valid = dv[1];
  assign b0.mem_instr = di[0];  assign b3.mem_instr = di[1];
  assign b0.mem_addr  = da[0];  assign b3.mem_addr  = da[1];
  assign b0.mem_wdata = dwd[0]; assign b3.mem_wdata = dwd[1];
  assign b0.mem_wstrb = dws[0]; assign b3.mem_wstrb = dws[1];
  assign rdy[0]  = b0.mem_ready; assign rdy[1]  = b3.mem_ready;
  assign rdat[0] = b0.mem_rdata; assign rdat[1] = b3.mem_rdata;

  native_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .bus(b0), .range_err(rerr[0]), .proto_err(perr[0]),
    .cnt_ifetch(cif[0]), .cnt_dread(cdr[0]), .cnt_dwrite(cdw[0]));
  native_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .bus(b3), .range_err(rerr[1]), .proto_err(perr[1]),
    .cnt_ifetch(cif[1]), .cnt_dread(cdr[1]), .cnt_dwrite(cdw[1]));

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_got;
  logic        re_got;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus transaction; scr perturbs addr/wdata after acceptance to prove they are latched.
  task automatic req(input int s, input logic instr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int lat, input bit scr, input string tag);
    int n;
    @(negedge clk);
    dv[s] = 1'b1; di[s] = instr; da[s] = a; dwd[s] = wd; dws[s] = ws;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scr && n == 1) begin da[s] = a ^ 32'h4; dwd[s] = ~wd; end
    end while (!rdy[s] && n < 40);
`ifdef MEM_RAND_STALL_EN
    chk({tag, "_lat"}, 32'((n - 1 >= lat + 1) && (n - 1 <= lat + 4)), 32'd1);
`else
    chk({tag, "_lat"}, 32'(n - 1), 32'(lat + 1));
`endif
    rd_got = rdat[s];
    re_got = rerr[s];
    dv[s] = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rdy[s]), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; di[i] = 1'b0; da[i] = '0; dwd[i] = '0; dws[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(rdy[0]),  32'd0);
    chk("rst_rdata",  rdat[1],      32'd0);
    chk("rst_range",  32'(rerr[0]), 32'd0);
    chk("rst_proto",  32'(perr[1]), 32'd0);
    chk("rst_ifetch", cif[0],       32'd0);
    chk("rst_dread",  cdr[1],       32'd0);
    chk("rst_dwrite", cdw[0],       32'd0);
    reset = 1'b0;

    // LATENCY=0 responder
    req(0, 1'b0, 32'h0, 32'h0140_0093, 4'hF, 0, 1'b0, "w0");
    chk("w0_rdata", rd_got, 32'd0);
    req(0, 1'b1, 32'h0, 32'h0, 4'h0, 0, 1'b0, "fetch0");
    chk("fetch0_rdata", rd_got, 32'h0140_0093);
    chk("fetch0_range", 32'(re_got), 32'd0);
    chk("fetch0_cif", cif[0], 32'd1);
    chk("fetch0_cdw", cdw[0], 32'd1);
    req(0, 1'b0, 32'h200, 32'h1122_3344, 4'hF, 0, 1'b0, "w200");
    req(0, 1'b0, 32'h200, 32'hAABB_CCDD, 4'b0010, 0, 1'b0, "wstrb");
    req(0, 1'b0, 32'h200, 32'h0, 4'h0, 0, 1'b0, "r200");
    chk("r200_rdata", rd_got, 32'h1122_CC44);
    req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, "roob");
    chk("roob_rdata", rd_got, 32'hDEAD_BEEF);
    chk("roob_range", 32'(re_got), 32'd1);
    req(0, 1'b0, 32'h1000, 32'h5555_5555, 4'hF, 0, 1'b0, "woob");
    chk("woob_rdata", rd_got, 32'd0);
    chk("woob_range", 32'(re_got), 32'd1);
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, "r0");
    chk("r0_unchanged", rd_got, 32'h0140_0093);
    req(0, 1'b0, 32'hFFC, 32'h5A5A_0FFC, 4'hF, 0, 1'b0, "wlast");
    req(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, 1'b1, "rlast");
    chk("rlast_rdata", rd_got, 32'h5A5A_0FFC);
    chk("rlast_range", 32'(re_got), 32'd0);
    chk("l0_cif", cif[0], 32'd1);
    chk("l0_cdr", cdr[0], 32'd4);
    chk("l0_cdw", cdw[0], 32'd5);
    chk("l0_proto", 32'(perr[0]), 32'd0);

    // LATENCY=3 responder
    req(1, 1'b0, 32'h104, 32'h0000_0104, 4'hF, 3, 1'b0, "w104");
    req(1, 1'b0, 32'h100, 32'h0000_0014, 4'hF, 3, 1'b1, "sw100");
    req(1, 1'b0, 32'h100, 32'h0, 4'h0, 3, 1'b1, "lw100");
    chk("lw100_rdata", rd_got, 32'h0000_0014);
    req(1, 1'b0, 32'h104, 32'h0, 4'h0, 3, 1'b0, "lw104");
    chk("lw104_rdata", rd_got, 32'h0000_0104);
    chk("l3_cdw", cdw[1], 32'd2);
    chk("l3_cdr", cdr[1], 32'd2);

    // valid withdrawn during WAIT
    @(negedge clk);
    dv[1] = 1'b1; di[1] = 1'b0; da[1] = 32'h100; dwd[1] = 32'h0000_0BAD; dws[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    dv[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[1]) seen = 1'b1;
    end
    chk("proto_noready", 32'(seen), 32'd0);
    chk("proto_err", 32'(perr[1]), 32'd1);
    chk("proto_cdw", cdw[1], 32'd2);
    req(1, 1'b0, 32'h100, 32'h0, 4'h0, 3, 1'b0, "proto_rd");
    chk("proto_word", rd_got, 32'h0000_0014);

    // reset in the middle of a write's wait states
    @(negedge clk);
    dv[1] = 1'b1; di[1] = 1'b0; da[1] = 32'h100; dwd[1] = 32'h0000_0099; dws[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 32'(rdy[1]), 32'd0);
    chk("mrst_cdw", cdw[1], 32'd0);
    chk("mrst_cdr", cdr[1], 32'd0);
    chk("mrst_proto", 32'(perr[1]), 32'd0);
    chk("mrst_l0_cdw", cdw[0], 32'd0);
    reset = 1'b0;
    dv[1] = 1'b0;
    req(1, 1'b0, 32'h100, 32'h0, 4'h0, 3, 1'b0, "mrst_rd");
    chk("mrst_word", rd_got, 32'h0000_0014);
    chk("mrst_cdr_after", cdr[1], 32'd1);
    chk("mrst_cdw_after", cdw[1], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
